// File: rtl/ball_turn_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ball_turn_arbiter_if
// Brief    : Joystick/ball bus between the turn arbiter and its neighbours.
// Revision : 1.0 - initial release
// ============================================================================
interface ball_turn_arbiter_if;
    logic        start;
    logic        p0_valid;
    logic [3:0]  p0_x;
    logic [3:0]  p0_y;
    logic        p1_valid;
    logic [3:0]  p1_x;
    logic [3:0]  p1_y;
    logic [11:0] hor_pos;
    logic [10:0] ver_pos;
    logic        ball_reset;
    logic [3:0]  x_axis;
    logic [3:0]  y_axis;
    logic        owner;
    logic [1:0]  state;
    logic [7:0]  turn_count;

    modport master (
        output start, p0_valid, p0_x, p0_y, p1_valid, p1_x, p1_y, hor_pos, ver_pos,
        input  ball_reset, x_axis, y_axis, owner, state, turn_count
    );

    modport slave (
        input  start, p0_valid, p0_x, p0_y, p1_valid, p1_x, p1_y, hor_pos, ver_pos,
        output ball_reset, x_axis, y_axis, owner, state, turn_count
    );
endinterface
`default_nettype wire

// File: rtl/ball_turn_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ball_turn_arbiter
// Brief    : Grants the bouncing-ball axis inputs to one of two players in timed turns.
// Revision : 1.0 - initial release
// ============================================================================
module ball_turn_arbiter #(
    parameter int unsigned TICK_PERIOD = 524289,
    parameter int unsigned TURN_TICKS  = 64,
    parameter int unsigned ARM_CYCLES  = 4
) (
    input  wire logic           clk_i,
    input  wire logic           rst_i,
    ball_turn_arbiter_if.slave  bus
);
    localparam int unsigned C_TICK_W = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam int unsigned C_TURN_W = (TURN_TICKS > 1)  ? $clog2(TURN_TICKS)  : 1;
    localparam int unsigned C_ARM_W  = (ARM_CYCLES > 1)  ? $clog2(ARM_CYCLES)  : 1;
    localparam logic [C_TICK_W-1:0] C_TICK_LAST = C_TICK_W'(TICK_PERIOD - 1);
    localparam logic [C_TURN_W-1:0] C_TURN_LAST = C_TURN_W'(TURN_TICKS - 1);
    localparam logic [C_ARM_W-1:0]  C_ARM_LAST  = C_ARM_W'(ARM_CYCLES - 1);
    localparam logic [3:0] C_X_NEUTRAL = 4'd8;
    localparam logic [3:0] C_Y_NEUTRAL = 4'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        PLAY  = 2'd2,
        PAUSE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic [C_TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [C_TURN_W-1:0] turn_ticks_q, turn_ticks_d;
    logic [C_ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
    logic [7:0]          turn_count_q, turn_count_d;
    logic [3:0]          x_q, x_d;
    logic [3:0]          y_q, y_d;
    logic                ball_reset_q, ball_reset_d;

    logic w_owner_valid;
    logic w_other_valid;
    logic w_tick;
    logic w_wrap;
    logic w_handoff;

    assign w_owner_valid = owner_q ? bus.p1_valid : bus.p0_valid;
    assign w_other_valid = owner_q ? bus.p0_valid : bus.p1_valid;
    assign w_tick        = (state_q == PLAY) && (tick_cnt_q == C_TICK_LAST);
    assign w_wrap        = (bus.hor_pos == 12'd1) || (bus.ver_pos == 11'd1);
    // Dropout wins outright; wrap and turn expiry only count on a tick.
    assign w_handoff     = (state_q == PLAY) &&
                           (!w_owner_valid || (w_tick && (w_wrap || (turn_ticks_q == C_TURN_LAST))));

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        tick_cnt_d   = tick_cnt_q;
        turn_ticks_d = turn_ticks_q;
        arm_cnt_d    = arm_cnt_q;
        turn_count_d = turn_count_q;
        x_d          = C_X_NEUTRAL;
        y_d          = C_Y_NEUTRAL;
        ball_reset_d = 1'b0;

        case (state_q)
            IDLE: begin
                ball_reset_d = 1'b1;
                tick_cnt_d   = '0;
                turn_ticks_d = '0;
                arm_cnt_d    = '0;
                if (bus.start) begin
                    state_d = ARM;
                    owner_d = !bus.p0_valid;
                end
            end
            ARM: begin
                ball_reset_d = 1'b1;
                tick_cnt_d   = '0;
                if (arm_cnt_q == C_ARM_LAST) begin
                    state_d      = PLAY;
                    ball_reset_d = 1'b0;
                end else begin
                    arm_cnt_d = arm_cnt_q + 1'b1;
                end
            end
            PLAY: begin
                tick_cnt_d = w_tick ? '0 : tick_cnt_q + 1'b1;
                if (w_handoff) begin
                    turn_ticks_d = '0;
                    turn_count_d = (turn_count_q == 8'hFF) ? turn_count_q : turn_count_q + 8'd1;
                    if (w_other_valid) begin
                        owner_d = !owner_q;
                    end else if (!w_owner_valid) begin
                        state_d = PAUSE;
                    end
                end else begin
                    if (w_tick) begin
                        turn_ticks_d = turn_ticks_q + 1'b1;
                    end
                    x_d = owner_q ? bus.p1_x : bus.p0_x;
                    y_d = owner_q ? bus.p1_y : bus.p0_y;
                end
            end
            PAUSE: begin
                if (bus.p0_valid || bus.p1_valid) begin
                    state_d = PLAY;
                    owner_d = !bus.p0_valid;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            tick_cnt_q   <= '0;
            turn_ticks_q <= '0;
            arm_cnt_q    <= '0;
            turn_count_q <= 8'd0;
            x_q          <= C_X_NEUTRAL;
            y_q          <= C_Y_NEUTRAL;
            ball_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            tick_cnt_q   <= tick_cnt_d;
            turn_ticks_q <= turn_ticks_d;
            arm_cnt_q    <= arm_cnt_d;
            turn_count_q <= turn_count_d;
            x_q          <= x_d;
            y_q          <= y_d;
            ball_reset_q <= ball_reset_d;
        end
    end

    assign bus.ball_reset = ball_reset_q;
    assign bus.x_axis     = x_q;
    assign bus.y_axis     = y_q;
    assign bus.owner      = owner_q;
    assign bus.state      = state_q;
    assign bus.turn_count = turn_count_q;
endmodule
`default_nettype wire

// File: tb/tb_ball_turn_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ball_turn_arbiter
// Brief    : Scenario and randomized checks of ball_turn_arbiter against a turn-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ball_turn_arbiter;
    localparam int TP  = 4;
    localparam int TT  = 3;
    localparam int ARMC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ball_turn_arbiter_if bus();

    ball_turn_arbiter #(
        .TICK_PERIOD (TP),
        .TURN_TICKS  (TT),
        .ARM_CYCLES  (ARMC)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: game phase, who owns, PLAY cycles elapsed in this game, ticks used this turn.
    logic [1:0] m_state;
    logic       m_owner;
    int         m_play_cyc;
    int         m_turn_ticks;
    int         m_arm;
    logic [7:0] m_count;
    logic [3:0] m_x, m_y;
    logic       m_br;

    function automatic logic [19:0] exp_vec();
        return {m_br, m_x, m_y, m_owner, m_state, m_count};
    endfunction

    function automatic logic [19:0] obs();
        return {bus.ball_reset, bus.x_axis, bus.y_axis, bus.owner, bus.state, bus.turn_count};
    endfunction

    task automatic model_step();
        bit tick, ov, oth, ended;
        logic [1:0] nxt;
        m_x = 4'd8;
        m_y = 4'd7;
        if (rst) begin
            m_state = 2'd0; m_owner = 1'b0; m_play_cyc = 0; m_turn_ticks = 0;
            m_arm = 0; m_count = 8'd0; m_br = 1'b1;
            return;
        end
        nxt = m_state;
        if (m_state == 2'd0) begin
            if (bus.start) begin
                nxt = 2'd1; m_arm = 0; m_play_cyc = 0; m_turn_ticks = 0;
                m_owner = bus.p0_valid ? 1'b0 : 1'b1;
            end
        end else if (m_state == 2'd1) begin
            m_arm++;
            if (m_arm == ARMC) nxt = 2'd2;
        end else if (m_state == 2'd2) begin
            tick = ((m_play_cyc % TP) == TP - 1);
            m_play_cyc++;
            ov  = m_owner ? bus.p1_valid : bus.p0_valid;
            oth = m_owner ? bus.p0_valid : bus.p1_valid;
            ended = !ov
                 || (tick && (bus.hor_pos == 12'd1 || bus.ver_pos == 11'd1))
                 || (tick && (m_turn_ticks + 1 == TT));
            if (ended) begin
                if (m_count != 8'd255) m_count = m_count + 8'd1;
                m_turn_ticks = 0;
                if (oth) m_owner = ~m_owner;
                else if (!ov) nxt = 2'd3;
            end else begin
                if (tick) m_turn_ticks++;
                m_x = m_owner ? bus.p1_x : bus.p0_x;
                m_y = m_owner ? bus.p1_y : bus.p0_y;
            end
        end else begin
            if (bus.p0_valid || bus.p1_valid) begin
                nxt = 2'd2;
                m_owner = bus.p0_valid ? 1'b0 : 1'b1;
            end
        end
        m_state = nxt;
        m_br = (nxt == 2'd0) || (nxt == 2'd1);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_idle_inputs();
        bus.start = 1'b0;
        bus.p0_valid = 1'b1; bus.p1_valid = 1'b1;
        bus.p0_x = 4'd3; bus.p0_y = 4'd12; bus.p1_x = 4'd14; bus.p1_y = 4'd1;
        bus.hor_pos = 12'd100; bus.ver_pos = 11'd100;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if (obs() !== {1'b1, 4'd8, 4'd7, 1'b0, 2'd0, 8'd0})
            $display("FAIL reset_state: got %h want %h", obs(), {1'b1, 4'd8, 4'd7, 1'b0, 2'd0, 8'd0});
        checks++;
        if (obs() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_model: got %h want %h", obs(), exp_vec());
        end
        if (obs() !== {1'b1, 4'd8, 4'd7, 1'b0, 2'd0, 8'd0}) errors++;
        rst = 1'b0;
    endtask

    task automatic test_start_and_turn();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++;
        if (bus.state !== 2'd1 || bus.ball_reset !== 1'b1) begin
            errors++;
            $display("FAIL arm_entry: state %0d br %0d want 1/1", bus.state, bus.ball_reset);
        end
        step();
        checks++;
        if (bus.state !== 2'd1 || bus.ball_reset !== 1'b1) begin
            errors++;
            $display("FAIL arm_hold: state %0d br %0d want 1/1", bus.state, bus.ball_reset);
        end
        step();
        checks++;
        if (bus.state !== 2'd2 || bus.ball_reset !== 1'b0 || bus.owner !== 1'b0 || bus.x_axis !== 4'd8) begin
            errors++;
            $display("FAIL play_entry: state %0d br %0d owner %0d x %0d want 2/0/0/8",
                     bus.state, bus.ball_reset, bus.owner, bus.x_axis);
        end
        step();
        checks++;
        if (bus.x_axis !== bus.p0_x || bus.y_axis !== bus.p0_y) begin
            errors++;
            $display("FAIL play_axes: x %0d y %0d want %0d %0d", bus.x_axis, bus.y_axis, bus.p0_x, bus.p0_y);
        end
        repeat (11) begin
            step();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL turn_model: got %h want %h", obs(), exp_vec());
            end
        end
        checks++;
        if (bus.owner !== 1'b1 || bus.turn_count !== 8'd1) begin
            errors++;
            $display("FAIL turn_expiry: owner %0d count %0d want 1/1", bus.owner, bus.turn_count);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] c0;
        int n;
        n = 0;
        while (m_owner != 1'b0 && n < 20) begin step(); n++; end
        checks++;
        if (m_owner != 1'b0 || bus.owner !== 1'b0) begin
            errors++;
            $display("FAIL wrap_setup: owner %0d want 0", bus.owner);
        end
        bus.hor_pos = 12'd1;
        c0 = m_count;
        n = 0;
        while (m_count == c0 && n < 8) begin step(); n++; end
        checks++;
        if (n > TP || bus.owner !== 1'b1 || bus.turn_count !== c0 + 8'd1) begin
            errors++;
            $display("FAIL wrap_handoff: cycles %0d owner %0d count %0d want <=%0d/1/%0d",
                     n, bus.owner, bus.turn_count, TP, c0 + 8'd1);
        end
        bus.hor_pos = 12'd100;
        c0 = bus.turn_count;
        repeat (TP * TT - 1) step();
        checks++;
        if (bus.turn_count !== c0 || bus.owner !== 1'b1) begin
            errors++;
            $display("FAIL wrap_restart_early: count %0d owner %0d want %0d/1", bus.turn_count, bus.owner, c0);
        end
        step();
        checks++;
        if (bus.turn_count !== c0 + 8'd1 || bus.owner !== 1'b0) begin
            errors++;
            $display("FAIL wrap_restart_full: count %0d owner %0d want %0d/0", bus.turn_count, bus.owner, c0 + 8'd1);
        end
    endtask

    task automatic test_dropout_pause();
        logic [7:0] c0;
        int n;
        n = 0;
        while (m_owner != 1'b1 && n < 20) begin step(); n++; end
        c0 = m_count;
        bus.p1_valid = 1'b0;
        step();
        checks++;
        if (bus.owner !== 1'b0 || bus.turn_count !== c0 + 8'd1 || bus.state !== 2'd2) begin
            errors++;
            $display("FAIL dropout: owner %0d count %0d state %0d want 0/%0d/2",
                     bus.owner, bus.turn_count, bus.state, c0 + 8'd1);
        end
        bus.p0_valid = 1'b0;
        step();
        checks++;
        if (bus.state !== 2'd3 || bus.x_axis !== 4'd8 || bus.y_axis !== 4'd7 || bus.turn_count !== c0 + 8'd2) begin
            errors++;
            $display("FAIL pause_entry: state %0d x %0d y %0d count %0d want 3/8/7/%0d",
                     bus.state, bus.x_axis, bus.y_axis, bus.turn_count, c0 + 8'd2);
        end
        step();
        checks++;
        if (obs() !== exp_vec()) begin
            errors++;
            $display("FAIL pause_hold: got %h want %h", obs(), exp_vec());
        end
        bus.p1_valid = 1'b1;
        step();
        checks++;
        if (bus.state !== 2'd2 || bus.owner !== 1'b1 || bus.turn_count !== c0 + 8'd2) begin
            errors++;
            $display("FAIL resume: state %0d owner %0d count %0d want 2/1/%0d",
                     bus.state, bus.owner, bus.turn_count, c0 + 8'd2);
        end
    endtask

    task automatic test_saturate_and_start();
        rst = 1'b1;
        set_idle_inputs();
        step();
        rst = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (2) step();
        for (int i = 0; i < 300; i++) begin
            bus.p0_valid = m_owner;
            bus.p1_valid = ~m_owner;
            step();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL sat_model: i %0d got %h want %h", i, obs(), exp_vec());
            end
        end
        checks++;
        if (bus.turn_count !== 8'd255) begin
            errors++;
            $display("FAIL saturate: count %0d want 255", bus.turn_count);
        end
        bus.p0_valid = 1'b1; bus.p1_valid = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        checks++;
        if (bus.state !== 2'd2 || bus.ball_reset !== 1'b0 || bus.turn_count !== 8'd255) begin
            errors++;
            $display("FAIL start_in_play: state %0d br %0d count %0d want 2/0/255",
                     bus.state, bus.ball_reset, bus.turn_count);
        end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (obs() !== {1'b1, 4'd8, 4'd7, 1'b0, 2'd0, 8'd0}) begin
            errors++;
            $display("FAIL mid_reset: got %h want %h", obs(), {1'b1, 4'd8, 4'd7, 1'b0, 2'd0, 8'd0});
        end
    endtask

    task automatic test_random();
        rst = 1'b1;
        set_idle_inputs();
        step();
        rst = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            bus.start = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 11) == 0) bus.p0_valid = ~bus.p0_valid;
            if ($urandom_range(0, 11) == 0) bus.p1_valid = ~bus.p1_valid;
            bus.p0_x = 4'($urandom); bus.p0_y = 4'($urandom);
            bus.p1_x = 4'($urandom); bus.p1_y = 4'($urandom);
            bus.hor_pos = ($urandom_range(0, 5) == 0) ? 12'd1 : 12'($urandom_range(2, 4095));
            bus.ver_pos = ($urandom_range(0, 5) == 0) ? 11'd1 : 11'($urandom_range(2, 2047));
            step();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL random: cycle %0d got %h want %h", i, obs(), exp_vec());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        set_idle_inputs();
        test_reset();
        test_start_and_turn();
        test_wrap();
        test_dropout_pause();
        test_saturate_and_start();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
